// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
//   Shared definitions for the data-memory arbiter:
//   - FSM state encodings (IDLE / HOLD0 / HOLD1)
//   - requester port index constants
//   - small helpers that map a port index to its one-hot grant and to the
//     matching HOLD state
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD0 = 2'd1;
  localparam logic [1:0] ST_HOLD1 = 2'd2;

  // Requester port indices
  localparam logic PORT0 = 1'b0;  // CPU load/store
  localparam logic PORT1 = 1'b1;  // DMA / debug loader

  // One-hot grant vector for a port index
  function automatic logic [1:0] port_onehot(input logic idx);
    return (idx == PORT1) ? 2'b10 : 2'b01;
  endfunction

  // HOLD state that belongs to a port index
  function automatic logic [1:0] hold_state(input logic idx);
    return (idx == PORT1) ? ST_HOLD1 : ST_HOLD0;
  endfunction

endpackage : dmem_arbiter_pkg

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles the two requester ports and the data-memory port of the arbiter.
//   Signals
//     req0/req1      access request per port
//     we0/we1        1 = write, 0 = read
//     lock0/lock1    keep ownership after this access
//     addr0/addr1    word address            [AW-1:0]
//     wdata0/wdata1  write data              [DW-1:0]
//     grant          one-hot, combinational  [1:0]
//     ack0/ack1      one-cycle pulse, cycle after the granted edge
//     rdata0/rdata1  data read at the granted edge, held otherwise
//     mem_we/mem_addr/mem_wdata  drive the data memory
//     mem_rdata      combinational read data of mem_addr
//   Modports
//     slave   the arbiter itself
//     master  the surrounding system (requesters plus the memory read path)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);

  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic          lock0;
  logic          lock1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;

  logic [1:0]    grant;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1,
    input  addr0, addr1, wdata0, wdata1,
    output grant, ack0, ack1, rdata0, rdata1,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1,
    output addr0, addr1, wdata0, wdata1,
    input  grant, ack0, ack1, rdata0, rdata1,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface : dmem_arbiter_if

// File: rtl/dmem_arbiter_arb_rr2.sv
// -----------------------------------------------------------------------------
// arb_rr2
//   Combinational two-way round-robin picker.
//   Ports
//     req   [1:0]  in   request vector
//     last         in   index of the most recently granted port
//     grant [1:0]  out  one-hot (or zero) grant
//   A lone request is granted directly; on a tie the port that was not
//   granted last wins.
// -----------------------------------------------------------------------------
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  import dmem_arbiter_pkg::*;

  always_comb begin
    // NOTE: every output of an always_comb gets a value on every path; a
    // default assignment up front is the simplest way to rule out a latch.
    grant = req;
    if (req == 2'b11) begin
      grant = port_onehot(~last);
    end
  end

endmodule : arb_rr2

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares a single-port data memory (combinational read, write on the rising
//   edge) between port 0 (CPU) and port 1 (DMA / debug loader). One access is
//   issued per clock; ties are resolved round-robin. A requester may assert
//   lock to keep ownership for a bounded burst of back-to-back accesses.
//   Ports
//     clk    in  clock, all state updates on the rising edge
//     rst_n  in  asynchronous active-low reset
//     bus    dmem_arbiter_if.slave : requester ports and memory port
//   Parameters
//     AW        word address width
//     DW        data width
//     MAX_HOLD  max consecutive granted cycles of one locked burst (>= 1)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  dmem_arbiter_if.slave      bus
);

  import dmem_arbiter_pkg::*;

  localparam int HCW = $clog2(MAX_HOLD + 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]     state;
  logic           last;       // index of the port granted most recently
  logic [HCW-1:0] hold_cnt;   // granted cycles of the current locked burst

  logic           ack0_q;
  logic           ack1_q;
  logic [DW-1:0]  rdata0_q;
  logic [DW-1:0]  rdata1_q;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [1:0]     req;
  logic [1:0]     rr_grant;
  logic [1:0]     grant;
  logic           gidx;       // index of the granted port (valid when grant != 0)
  logic           lock_g;     // lock input of the granted port
  logic           cont_burst; // this grant extends the burst already held
  logic [HCW-1:0] cnt_new;    // burst length including this grant

  assign req = {bus.req1, bus.req0};

  arb_rr2 u_rr (
    .req   (req),
    .last  (last),
    .grant (rr_grant)
  );

  // The owner of a burst is served exclusively while it keeps requesting.
  // If the owner drops its request the cycle is arbitrated as if idle.
  // Grant is forced low while reset is asserted so no access can issue.
  always_comb begin
    grant = 2'b00;
    if (rst_n) begin
      case (state)
        ST_HOLD0: grant = bus.req0 ? port_onehot(PORT0) : rr_grant;
        ST_HOLD1: grant = bus.req1 ? port_onehot(PORT1) : rr_grant;
        default:  grant = rr_grant;
      endcase
    end
  end

  assign gidx       = grant[1];
  assign lock_g     = gidx ? bus.lock1 : bus.lock0;
  assign cont_burst = (state == hold_state(gidx));
  assign cnt_new    = cont_burst ? hold_cnt + HCW'(1) : HCW'(1);

  assign bus.grant  = grant;

  // ---------------------------------------------------------------------------
  // Memory port mux
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (grant[0]) begin
      bus.mem_we    = bus.we0;
      bus.mem_addr  = bus.addr0;
      bus.mem_wdata = bus.wdata0;
    end else if (grant[1]) begin
      bus.mem_we    = bus.we1;
      bus.mem_addr  = bus.addr1;
      bus.mem_wdata = bus.wdata1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and burst counter
  //   cnt_new counts the grant issuing at this edge, so a burst that reaches
  //   MAX_HOLD granted cycles is released at that same edge. With last set to
  //   the releasing port, a waiting other port wins the very next tie.
  // ---------------------------------------------------------------------------
  // NOTE: clocked state is assigned with <= so every flop samples the values
  // from before the edge, independent of statement order inside the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      last     <= PORT1;      // port 0 wins the first tie after reset
      hold_cnt <= '0;
    end else if (grant != 2'b00) begin
      last <= gidx;
      if (lock_g && (cnt_new != HCW'(MAX_HOLD))) begin
        state    <= hold_state(gidx);
        hold_cnt <= cnt_new;
      end else begin
        state    <= ST_IDLE;
        hold_cnt <= '0;
      end
    end else begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Response registers
  //   rdata captures the memory word at the granted edge; for a write this is
  //   the word as it was before the write commits.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q <= grant[0];
      ack1_q <= grant[1];
      if (grant[0]) begin
        rdata0_q <= bus.mem_rdata;
      end
      if (grant[1]) begin
        rdata1_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.ack0   = ack0_q;
  assign bus.ack1   = ack1_q;
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed scenarios with hand-computed expectations followed by a random
//   phase. The stimulus process pushes expected grants and read data into
//   queues; a monitor on the falling edge pops and compares whenever the DUT
//   presents a grant expectation window or an ack.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int AW       = 10;
  localparam int DW       = 32;
  localparam int MAX_HOLD = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural 1024x32 data memory, combinational read
  logic [DW-1:0] mem [1024] = '{default: '0};
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  // Reference memory contents, updated by the stimulus side only
  logic [DW-1:0] mdl [1024] = '{default: '0};

  // Scoreboard
  int            checks = 0;
  int            errors = 0;
  logic [1:0]    q_gnt [$];
  logic [DW-1:0] q_rd0 [$];
  logic [DW-1:0] q_rd1 [$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (q_gnt.size() > 0) check("grant", DW'(bus.grant), DW'(q_gnt.pop_front()));
    if (bus.ack0) begin
      if (q_rd0.size() == 0) begin
        checks++; errors++;
        $display("FAIL ack0_unexpected: ack0=1 with no outstanding grant at %0t", $time);
      end else begin
        check("rdata0", bus.rdata0, q_rd0.pop_front());
      end
    end
    if (bus.ack1) begin
      if (q_rd1.size() == 0) begin
        checks++; errors++;
        $display("FAIL ack1_unexpected: ack1=1 with no outstanding grant at %0t", $time);
      end else begin
        check("rdata1", bus.rdata1, q_rd1.pop_front());
      end
    end
  end

  // Stimulus helpers
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p0(input logic r, input logic w, input logic l,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req0 = r; bus.we0 = w; bus.lock0 = l; bus.addr0 = a; bus.wdata0 = d;
  endtask

  task automatic set_p1(input logic r, input logic w, input logic l,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req1 = r; bus.we1 = w; bus.lock1 = l; bus.addr1 = a; bus.wdata1 = d;
  endtask

  task automatic idle_ports();
    set_p0(1'b0, 1'b0, 1'b0, '0, '0);
    set_p1(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Directed cycle: expected grant and read data are supplied by the caller
  task automatic expect_cycle(input logic [1:0] g, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    q_gnt.push_back(g);
    if (g[0]) begin
      q_rd0.push_back(e0);
      if (bus.we0) mdl[bus.addr0] = bus.wdata0;
    end
    if (g[1]) begin
      q_rd1.push_back(e1);
      if (bus.we1) mdl[bus.addr1] = bus.wdata1;
    end
  endtask

  // Random cycle: read data comes from the reference memory (old word first)
  task automatic push_rand(input logic [1:0] g);
    if (g[0]) begin
      q_rd0.push_back(mdl[bus.addr0]);
      if (bus.we0) mdl[bus.addr0] = bus.wdata0;
    end
    if (g[1]) begin
      q_rd1.push_back(mdl[bus.addr1]);
      if (bus.we1) mdl[bus.addr1] = bus.wdata1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"},  DW'(bus.grant),  '0);
    check({tag, "_ack0"},   DW'(bus.ack0),   '0);
    check({tag, "_ack1"},   DW'(bus.ack1),   '0);
    check({tag, "_mem_we"}, DW'(bus.mem_we), '0);
    check({tag, "_rdata0"}, bus.rdata0,      '0);
    check({tag, "_rdata1"}, bus.rdata1,      '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q_gnt.delete(); q_rd0.delete(); q_rd1.delete();
    idle_ports();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [1:0] g;
  int         wait0;
  int         wait1;

  initial begin
    idle_ports();

    // 1. Reset state, then port 0 write/read at 0x004
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    next(); set_p0(1'b1, 1'b1, 1'b0, 10'h004, 32'hDEADBEEF); expect_cycle(2'b01, 32'h0, 32'h0);
    next(); set_p0(1'b1, 1'b0, 1'b0, 10'h004, 32'h0);        expect_cycle(2'b01, 32'hDEADBEEF, 32'h0);
    next(); idle_ports();                                      expect_cycle(2'b00, 32'h0, 32'h0);
    next();

    // 2. Both request every cycle, no lock: 01,10,01,10,... starting with port 0
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      next();
      set_p0(1'b1, c <= 2, 1'b0, 10'h010, 32'hA0);
      set_p1(1'b1, c <= 2, 1'b0, 10'h020, 32'hB0);
      expect_cycle((c % 2 == 1) ? 2'b01 : 2'b10,
                   (c == 1) ? 32'h0 : 32'hA0,
                   (c == 2) ? 32'h0 : 32'hB0);
    end
    next(); idle_ports(); expect_cycle(2'b00, 32'h0, 32'h0);

    // 3. Port 1 locked burst capped at MAX_HOLD, port 0 waiting
    for (int c = 1; c <= 14; c++) begin
      next();
      set_p1(c <= 12, 1'b0, 1'b1, 10'h020, 32'h0);
      set_p0((c >= 2) && (c <= 13), 1'b0, 1'b0, 10'h010, 32'h0);
      expect_cycle((c <= 8 || (c >= 10 && c <= 12)) ? 2'b10 :
                   (c == 9 || c == 13)              ? 2'b01 : 2'b00,
                   32'hA0, 32'hB0);
    end

    // 4. Same address, write on port 0 and read on port 1 in one cycle
    next();
    do_reset();
    next();
    set_p0(1'b1, 1'b1, 1'b0, 10'h3FF, 32'h1234);
    set_p1(1'b1, 1'b0, 1'b0, 10'h3FF, 32'h0);
    expect_cycle(2'b01, 32'h0, 32'h0);
    next(); set_p0(1'b0, 1'b0, 1'b0, '0, '0); expect_cycle(2'b10, 32'h0, 32'h1234);
    next(); idle_ports();                     expect_cycle(2'b00, 32'h0, 32'h0);

    // 5. Reset mid-burst with ack pending
    next(); set_p1(1'b1, 1'b1, 1'b1, 10'h030, 32'h55); expect_cycle(2'b10, 32'h0, 32'h0);
    next();                                             expect_cycle(2'b10, 32'h0, 32'h55);
    next();
    rst_n = 1'b0;
    q_gnt.delete(); q_rd0.delete(); q_rd1.delete();
    #1;
    check_reset_outputs("midburst_reset");
    idle_ports();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    next();
    set_p0(1'b1, 1'b0, 1'b0, 10'h030, 32'h0);
    set_p1(1'b1, 1'b0, 1'b0, 10'h030, 32'h0);
    expect_cycle(2'b01, 32'h55, 32'h0);
    next(); expect_cycle(2'b10, 32'h0, 32'h55);
    next(); idle_ports(); expect_cycle(2'b00, 32'h0, 32'h0);

    // 6. Random traffic
    wait0 = 0;
    wait1 = 0;
    for (int c = 0; c < 10000; c++) begin
      next();
      set_p0($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             10'($urandom_range(0, 15)), $urandom);
      set_p1($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             10'($urandom_range(0, 15)), $urandom);
      #1;
      g = bus.grant;
      check("rand_two_hot",      DW'(g == 2'b11), '0);
      check("rand_grant_no_req", DW'((g & ~{bus.req1, bus.req0}) != 2'b00), '0);
      check("rand_idle_with_req", DW'((g == 2'b00) && (bus.req0 || bus.req1)), '0);
      wait0 = (bus.req0 && !g[0]) ? wait0 + 1 : 0;
      wait1 = (bus.req1 && !g[1]) ? wait1 + 1 : 0;
      check("rand_wait0_bound", DW'(wait0 > MAX_HOLD + 1), '0);
      check("rand_wait1_bound", DW'(wait1 > MAX_HOLD + 1), '0);
      push_rand(g);
    end
    next(); idle_ports();
    next();
    @(negedge clk);
    #1;
    check("drain_rd0", DW'(q_rd0.size()), '0);
    check("drain_rd1", DW'(q_rd1.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_dmem_arbiter
